// File: rtl/snitch_event_counters_if.sv
// Register-port bundle for the event-counter unit: one request per cycle,
// response (rvalid/rdata/err) one cycle later.
interface snitch_event_counters_if #(
    parameter int AddrWidth = 4
);
    logic                 req;
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [31:0]          wdata;
    logic                 rvalid;
    logic [31:0]          rdata;
    logic                 err;

    modport master (output req, we, addr, wdata, input rvalid, rdata, err);
    modport slave  (input req, we, addr, wdata, output rvalid, rdata, err);
endinterface

// File: rtl/snitch_event_counters.sv
// Performance-counter unit: per-hart event strobes are masked, popcounted and
// accumulated into programmable wrap/saturate counters behind a 32-bit register port.
module snitch_event_counters #(
    parameter int NrCores      = 8,
    parameter int NrCounters   = 4,
    parameter int NrEvents     = 7,
    parameter int CounterWidth = 48
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NrCores*NrEvents-1:0] core_events_i,
    snitch_event_counters_if.slave      cfg,
    output logic                        irq_o
);
    localparam int AddrWidth = $clog2(NrCounters) + 2;
    localparam int IncWidth  = $clog2(NrCores + 1);
    localparam int HiWidth   = CounterWidth - 32;
    localparam int SumWidth  = CounterWidth + 1;

    typedef logic [CounterWidth-1:0] cnt_t;

    logic [NrCores*NrEvents-1:0] ev_q;
    cnt_t                        cnt_q    [NrCounters];
    logic [HiWidth-1:0]          shadow_q [NrCounters];
    logic [NrCores-1:0]          mask_q   [NrCounters];
    logic [3:0]                  sel_q    [NrCounters];
    logic [NrCounters-1:0]       en_q, sat_q, ovf_q, irq_en_q;

    logic [AddrWidth-1:0]  cnt_idx;
    logic [1:0]            reg_idx;
    logic                  idx_ok, sel_ok, acc_err, wr_ok, rd_ok;
    logic [NrCounters-1:0] hit, cfg_wr, mask_wr, lo_wr, hi_wr, lo_rd;
    logic [31:0]           rdata_d;
    logic [15:0]           ev_hart [NrCores];
    logic [IncWidth-1:0]   inc     [NrCounters];
    logic [CounterWidth:0] upd     [NrCounters];

    // Returns {overflow, next count}; saturation clamps the count to all-ones.
    function automatic logic [CounterWidth:0] count_step(input cnt_t cnt,
                                                         input logic [IncWidth-1:0] add,
                                                         input logic sat);
        logic [CounterWidth:0] sum;
        sum = {1'b0, cnt} + SumWidth'(add);
        if (sat && sum[CounterWidth]) return {1'b1, {CounterWidth{1'b1}}};
        return sum;
    endfunction

    assign cnt_idx = cfg.addr >> 2;
    assign reg_idx = cfg.addr[1:0];
    assign idx_ok  = cnt_idx < AddrWidth'(NrCounters);
    assign sel_ok  = {1'b0, cfg.wdata[11:8]} < 5'(NrEvents);
    assign acc_err = cfg.req & (~idx_ok | (cfg.we & (reg_idx == 2'd0) & ~sel_ok));
    assign wr_ok   = cfg.req & cfg.we & ~acc_err;
    assign rd_ok   = cfg.req & ~cfg.we & ~acc_err;

    always_comb begin
        hit     = '0;
        cfg_wr  = '0;
        mask_wr = '0;
        lo_wr   = '0;
        hi_wr   = '0;
        lo_rd   = '0;
        rdata_d = '0;
        for (int c = 0; c < NrCounters; c++) begin
            hit[c]     = (cnt_idx == AddrWidth'(c));
            cfg_wr[c]  = wr_ok & hit[c] & (reg_idx == 2'd0);
            mask_wr[c] = wr_ok & hit[c] & (reg_idx == 2'd1);
            lo_wr[c]   = wr_ok & hit[c] & (reg_idx == 2'd2);
            hi_wr[c]   = wr_ok & hit[c] & (reg_idx == 2'd3);
            lo_rd[c]   = rd_ok & hit[c] & (reg_idx == 2'd2);
            if (rd_ok && hit[c]) begin
                case (reg_idx)
                    2'd0:    rdata_d = {20'd0, sel_q[c], 4'd0, irq_en_q[c], ovf_q[c], sat_q[c], en_q[c]};
                    2'd1:    rdata_d = 32'(mask_q[c]);
                    2'd2:    rdata_d = cnt_q[c][31:0];
                    default: rdata_d = 32'(shadow_q[c]);
                endcase
            end
        end
    end

    // Stage 1: masked popcount of the selected event bit across harts.
    always_comb begin
        for (int h = 0; h < NrCores; h++) begin
            ev_hart[h] = 16'(ev_q[h*NrEvents +: NrEvents]);
        end
        for (int c = 0; c < NrCounters; c++) begin
            inc[c] = '0;
            for (int h = 0; h < NrCores; h++) begin
                inc[c] = inc[c] + IncWidth'(ev_hart[h][sel_q[c]] & mask_q[c][h]);
            end
            upd[c] = count_step(cnt_q[c], inc[c], sat_q[c]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ev_q       <= '0;
            en_q       <= '0;
            sat_q      <= '0;
            ovf_q      <= '0;
            irq_en_q   <= '0;
            cfg.rvalid <= 1'b0;
            cfg.rdata  <= '0;
            cfg.err    <= 1'b0;
            irq_o      <= 1'b0;
            for (int c = 0; c < NrCounters; c++) begin
                cnt_q[c]    <= '0;
                shadow_q[c] <= '0;
                mask_q[c]   <= '0;
                sel_q[c]    <= '0;
            end
        end else begin
            ev_q       <= core_events_i;
            cfg.rvalid <= cfg.req;
            cfg.rdata  <= rdata_d;
            cfg.err    <= acc_err;
            irq_o      <= |(ovf_q & irq_en_q);
            for (int c = 0; c < NrCounters; c++) begin
                if (cfg_wr[c]) begin
                    en_q[c]     <= cfg.wdata[0];
                    sat_q[c]    <= cfg.wdata[1];
                    irq_en_q[c] <= cfg.wdata[3];
                    sel_q[c]    <= cfg.wdata[11:8];
                end
                if (mask_wr[c]) mask_q[c] <= cfg.wdata[NrCores-1:0];
                // Upper half is latched on the low read so the pair reads atomically.
                if (lo_rd[c]) shadow_q[c] <= cnt_q[c][CounterWidth-1:32];
                if (lo_wr[c])      cnt_q[c][31:0]              <= cfg.wdata;
                else if (hi_wr[c]) cnt_q[c][CounterWidth-1:32] <= cfg.wdata[HiWidth-1:0];
                else if (en_q[c])  cnt_q[c]                    <= upd[c][CounterWidth-1:0];
                ovf_q[c] <= (en_q[c] & upd[c][CounterWidth] & ~lo_wr[c] & ~hi_wr[c])
                          | (ovf_q[c] & ~(cfg_wr[c] & cfg.wdata[2]));
            end
        end
    end
endmodule

// File: tb/tb_snitch_event_counters.sv
// Directed bench for snitch_event_counters: register-map vector table plus
// hand-written counting, wrap, saturate, atomic-read, collision and reset sequences.
module tb_snitch_event_counters;
    localparam int NrCores      = 8;
    localparam int NrCounters   = 3;
    localparam int NrEvents     = 7;
    localparam int CounterWidth = 48;
    localparam int AddrWidth    = $clog2(NrCounters) + 2;

    typedef struct {
        logic                 we;
        logic [AddrWidth-1:0] addr;
        logic [31:0]          wdata;
        logic [31:0]          exp_rdata;
        logic                 exp_err;
    } vec_t;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic [NrCores*NrEvents-1:0] core_events = '0;
    logic                        irq;
    int                          checks = 0;
    int                          failures = 0;
    vec_t                        vecs[$];

    snitch_event_counters_if #(.AddrWidth(AddrWidth)) bus ();

    snitch_event_counters #(
        .NrCores(NrCores), .NrCounters(NrCounters),
        .NrEvents(NrEvents), .CounterWidth(CounterWidth)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .core_events_i(core_events),
        .cfg(bus), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic access(input logic we, input logic [AddrWidth-1:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output logic rvalid);
        bus.req   = 1'b1;
        bus.we    = we;
        bus.addr  = addr;
        bus.wdata = wdata;
        cyc(1);
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        rdata     = bus.rdata;
        err       = bus.err;
        rvalid    = bus.rvalid;
    endtask

    task automatic rd(input string name, input logic [AddrWidth-1:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        logic        e, v;
        access(1'b0, addr, 32'h0, r, e, v);
        check(name, {v, e, r}, {1'b1, 1'b0, exp});
    endtask

    task automatic wr(input logic [AddrWidth-1:0] addr, input logic [31:0] data);
        logic [31:0] r;
        logic        e, v;
        access(1'b1, addr, data, r, e, v);
        check("write_resp", {v, e, r}, {1'b1, 1'b0, 32'h0});
    endtask

    function automatic logic [NrCores*NrEvents-1:0] ev(input logic [NrCores-1:0] harts, input int b);
        logic [NrCores*NrEvents-1:0] v = '0;
        for (int h = 0; h < NrCores; h++) if (harts[h]) v[h*NrEvents + b] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [31:0] r;
        logic        e, v;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

        cyc(2);
        check("reset_outputs", {bus.rvalid, bus.err, bus.rdata, irq}, 64'h0);
        rst_n = 1'b1;
        cyc(1);

        // Register-map table: reset readback, field masking, error decode, shadow behaviour.
        for (int a = 0; a < 4 * NrCounters; a++) vecs.push_back('{1'b0, AddrWidth'(a), 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 4'd1,  32'hFFFF_FF0F, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 4'd1,  32'h0,         32'h0000_000F, 1'b0});
        vecs.push_back('{1'b1, 4'd0,  32'hFFFF_F3FA, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 4'd0,  32'h0,         32'h0000_030A, 1'b0});
        vecs.push_back('{1'b1, 4'd0,  32'h0000_0701, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 4'd0,  32'h0,         32'h0000_030A, 1'b0});
        vecs.push_back('{1'b1, 4'd4,  32'h0000_0F01, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 4'd4,  32'h0,         32'h0,         1'b0});
        vecs.push_back('{1'b0, 4'd12, 32'h0,         32'h0,         1'b1});
        vecs.push_back('{1'b1, 4'd14, 32'hFFFF_FFFF, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 4'd15, 32'h0,         32'h0,         1'b1});
        vecs.push_back('{1'b1, 4'd10, 32'h1234_5678, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 4'd10, 32'h0,         32'h1234_5678, 1'b0});
        vecs.push_back('{1'b1, 4'd11, 32'hABCD_0123, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 4'd11, 32'h0,         32'h0,         1'b0});
        vecs.push_back('{1'b0, 4'd10, 32'h0,         32'h1234_5678, 1'b0});
        vecs.push_back('{1'b0, 4'd11, 32'h0,         32'h0000_0123, 1'b0});
        vecs.push_back('{1'b1, 4'd8,  32'h0000_0600, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 4'd8,  32'h0,         32'h0000_0600, 1'b0});
        foreach (vecs[i]) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, r, e, v);
            check($sformatf("vec%0d", i), {v, e, r}, {1'b1, vecs[i].exp_err, vecs[i].exp_rdata});
        end

        // Basic counting on counter 0, retired-instruction bit, all harts.
        wr(4'd1, 32'hFF); wr(4'd2, 32'h0); wr(4'd3, 32'h0); wr(4'd0, 32'h301);
        core_events = ev(8'hFF, 3) | ev(8'hFF, 0) | ev(8'hFF, 2);
        cyc(10);
        core_events = '0;
        cyc(2);
        rd("t2_cnt_lo", 4'd2, 32'd80);
        rd("t2_cfg", 4'd0, 32'h301);
        check("t2_irq", irq, 0);
        wr(4'd1, 32'h05);
        core_events = ev(8'hFF, 3);
        cyc(1);
        core_events = '0;
        cyc(2);
        rd("t2_mask", 4'd2, 32'd82);

        // Wrap with interrupt.
        wr(4'd0, 32'h300); wr(4'd1, 32'hFF); wr(4'd3, 32'hFFFF); wr(4'd2, 32'hFFFF_FFFE); wr(4'd0, 32'h309);
        core_events = ev(8'h07, 3);
        cyc(1);
        core_events = '0;
        check("t3_irq_c1", irq, 0);
        cyc(1);
        check("t3_irq_c2", irq, 0);
        cyc(1);
        check("t3_irq_c3", irq, 1);
        rd("t3_lo", 4'd2, 32'd1);
        rd("t3_hi", 4'd3, 32'd0);
        rd("t3_cfg", 4'd0, 32'h30D);
        wr(4'd0, 32'h30D);
        check("t3_irq_hold", irq, 1);
        cyc(1);
        check("t3_irq_clr", irq, 0);
        rd("t3_cfg_clr", 4'd0, 32'h309);

        // Saturate.
        wr(4'd0, 32'h300); wr(4'd3, 32'hFFFF); wr(4'd2, 32'hFFFF_FFFE); wr(4'd0, 32'h303);
        core_events = ev(8'h07, 3);
        cyc(1);
        core_events = '0;
        cyc(2);
        rd("t4_lo", 4'd2, 32'hFFFF_FFFF);
        rd("t4_hi", 4'd3, 32'h0000_FFFF);
        rd("t4_cfg", 4'd0, 32'h307);
        check("t4_irq", irq, 0);
        core_events = ev(8'hFF, 3);
        cyc(2);
        core_events = '0;
        cyc(2);
        rd("t4_lo_hold", 4'd2, 32'hFFFF_FFFF);
        rd("t4_hi_hold", 4'd3, 32'h0000_FFFF);
        wr(4'd0, 32'h307);
        cyc(3);
        rd("t4_no_ovf", 4'd0, 32'h303);

        // Atomic 64-bit read across a carry into the upper half (counter 1).
        wr(4'd5, 32'h01); wr(4'd7, 32'h0); wr(4'd6, 32'hFFFF_FFFF); wr(4'd4, 32'h001);
        core_events = ev(8'h01, 0);
        rd("t5_lo0", 4'd6, 32'hFFFF_FFFF);
        rd("t5_hi0", 4'd7, 32'h0);
        rd("t5_lo1", 4'd6, 32'h0);
        rd("t5_hi1", 4'd7, 32'h1);
        core_events = '0;

        // Write wins over a same-cycle increment (counter 2).
        wr(4'd9, 32'hFF); wr(4'd8, 32'h101);
        core_events = ev(8'hFF, 1);
        cyc(1);
        core_events = '0;
        wr(4'd10, 32'd5);
        rd("t6_lo", 4'd10, 32'd5);
        rd("t6_hi", 4'd11, 32'h123);
        core_events = ev(8'hFF, 1);
        cyc(1);
        core_events = '0;
        cyc(2);
        rd("t6_resume", 4'd10, 32'd13);

        // Asynchronous reset in the middle of an overflowing count.
        wr(4'd0, 32'h30B);
        core_events = ev(8'hFF, 3);
        cyc(3);
        check("rst_irq_before", irq, 1);
        #3 rst_n = 1'b0;
        #1 check("rst_async", {irq, bus.rvalid}, 0);
        cyc(1);
        core_events = '0;
        rst_n = 1'b1;
        cyc(1);
        rd("rst_c0_lo", 4'd2, 32'h0);
        rd("rst_c0_cfg", 4'd0, 32'h0);
        rd("rst_c2_lo", 4'd10, 32'h0);
        rd("rst_c1_mask", 4'd5, 32'h0);
        check("rst_irq_after", irq, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
